// File: rtl/sys_issue_exec_if.sv
// rtl/sys_issue_exec_if.sv - issue, CSR and writeback signal bundle for sys_issue_exec
interface sys_issue_exec_if #(
    parameter int SPEC_STATES = 4,
    parameter int PRF_LEN     = 7,
    parameter int ROB_IDX_LEN = 6,
    parameter int XLEN        = 64,
    parameter int OP_LEN      = 3
);
    logic                   Stall;
    logic                   Flush;
    logic                   Kill_Enable;
    logic                   Update_KillMask;
    logic [SPEC_STATES-1:0] FUBR_SpecTag;
    logic                   Req_Valid;
    logic [ROB_IDX_LEN-1:0] Req_ROBIdx;
    logic [SPEC_STATES-1:0] Req_KillMask;
    logic [PRF_LEN-1:0]     Req_Prd;
    logic                   Req_PrdWe;
    logic [OP_LEN-1:0]      Req_Op;
    logic [11:0]            Req_CsrAddr;
    logic [XLEN-1:0]        Req_Src1;
    logic                   RSSYS_Issued_Valid;
    logic [ROB_IDX_LEN-1:0] ROB_HeadIdx;
    logic                   Csr_Req;
    logic [OP_LEN-1:0]      Csr_Op;
    logic [11:0]            Csr_Addr;
    logic [XLEN-1:0]        Csr_WrData;
    logic                   Csr_Ack;
    logic [XLEN-1:0]        Csr_RdData;
    logic                   Csr_Fault;
    logic                   Wakeup_Valid;
    logic                   Wakeup_RegWE;
    logic                   Wakeup_PrdType;
    logic [PRF_LEN-1:0]     Wakeup_Prd;
    logic                   Cmpl_Valid;
    logic [ROB_IDX_LEN-1:0] Cmpl_ROBIdx;
    logic [XLEN-1:0]        Cmpl_Data;
    logic                   Cmpl_Exception;
    logic                   Sys_Busy;

    modport master (
        output Stall, Flush, Kill_Enable, Update_KillMask, FUBR_SpecTag,
        output Req_Valid, Req_ROBIdx, Req_KillMask, Req_Prd, Req_PrdWe,
        output Req_Op, Req_CsrAddr, Req_Src1, ROB_HeadIdx,
        output Csr_Ack, Csr_RdData, Csr_Fault,
        input  RSSYS_Issued_Valid, Csr_Req, Csr_Op, Csr_Addr, Csr_WrData,
        input  Wakeup_Valid, Wakeup_RegWE, Wakeup_PrdType, Wakeup_Prd,
        input  Cmpl_Valid, Cmpl_ROBIdx, Cmpl_Data, Cmpl_Exception, Sys_Busy
    );

    modport slave (
        input  Stall, Flush, Kill_Enable, Update_KillMask, FUBR_SpecTag,
        input  Req_Valid, Req_ROBIdx, Req_KillMask, Req_Prd, Req_PrdWe,
        input  Req_Op, Req_CsrAddr, Req_Src1, ROB_HeadIdx,
        input  Csr_Ack, Csr_RdData, Csr_Fault,
        output RSSYS_Issued_Valid, Csr_Req, Csr_Op, Csr_Addr, Csr_WrData,
        output Wakeup_Valid, Wakeup_RegWE, Wakeup_PrdType, Wakeup_Prd,
        output Cmpl_Valid, Cmpl_ROBIdx, Cmpl_Data, Cmpl_Exception, Sys_Busy
    );
endinterface

// File: rtl/sys_issue_exec.sv
// rtl/sys_issue_exec.sv - system uop issue consumer: waits for ROB head, does CSR access, writes back
module sys_issue_exec #(
    parameter int SPEC_STATES = 4,
    parameter int PRF_LEN     = 7,
    parameter int ROB_IDX_LEN = 6,
    parameter int XLEN        = 64,
    parameter int OP_LEN      = 3,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    sys_issue_exec_if.slave   bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_HEAD = 2'd1,
        S_CSR_REQ   = 2'd2,
        S_WB        = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SPEC_STATES-1:0] held_km;
    logic [ROB_IDX_LEN-1:0] held_rob;
    logic [PRF_LEN-1:0]     held_prd;
    logic                   held_we;
    logic [OP_LEN-1:0]      held_op;
    logic [11:0]            held_addr;
    logic [XLEN-1:0]        held_src;
    logic [XLEN-1:0]        result;
    logic                   exc;
    logic [CNT_W-1:0]       tmo_cnt;

    logic req_killed;
    logic held_killed;
    logic head_match;
    logic tmo_hit;
    logic issue;
    logic in_csr;
    logic in_wb;

    assign req_killed  = bus.Kill_Enable & |(bus.FUBR_SpecTag & bus.Req_KillMask);
    assign held_killed = bus.Kill_Enable & |(bus.FUBR_SpecTag & held_km);
    assign head_match  = (bus.ROB_HeadIdx == held_rob);
    assign tmo_hit     = (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign issue       = (state == S_IDLE) & bus.Req_Valid & ~bus.Stall & ~bus.Flush
                         & ~rst & ~req_killed;
    assign in_csr      = (state == S_CSR_REQ);
    assign in_wb       = (state == S_WB);

    // State register; flush is folded into the next-state logic
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: kill beats head match in WAIT_HEAD, ack beats timeout in CSR_REQ
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (issue) state_nxt = S_WAIT_HEAD;
            end
            S_WAIT_HEAD: begin
                if (held_killed) begin
                    state_nxt = S_IDLE;
                end else if (head_match & ~bus.Stall) begin
                    state_nxt = S_CSR_REQ;
                end
            end
            S_CSR_REQ: begin
                if (bus.Csr_Ack | tmo_hit) state_nxt = S_WB;
            end
            S_WB: begin
                if (~bus.Stall) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.Flush) state_nxt = S_IDLE;
    end

    // Held uop fields, killmask tracking, timeout counter and CSR result capture
    always_ff @(posedge clk) begin
        if (rst | bus.Flush) begin
            held_km <= '0;
            tmo_cnt <= '0;
            exc     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        held_rob  <= bus.Req_ROBIdx;
                        held_prd  <= bus.Req_Prd;
                        held_we   <= bus.Req_PrdWe;
                        held_op   <= bus.Req_Op;
                        held_addr <= bus.Req_CsrAddr;
                        held_src  <= bus.Req_Src1;
                        held_km   <= bus.Update_KillMask ? (bus.Req_KillMask & ~bus.FUBR_SpecTag)
                                                         : bus.Req_KillMask;
                        exc       <= 1'b0;
                    end
                end
                S_WAIT_HEAD: begin
                    if (bus.Update_KillMask) held_km <= held_km & ~bus.FUBR_SpecTag;
                    if (~held_killed & head_match & ~bus.Stall) tmo_cnt <= '0;
                end
                S_CSR_REQ: begin
                    if (bus.Csr_Ack) begin
                        result <= bus.Csr_RdData;
                        exc    <= bus.Csr_Fault;
                    end else if (tmo_hit) begin
                        result <= '0;
                        exc    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.RSSYS_Issued_Valid = issue;
    assign bus.Sys_Busy           = (state != S_IDLE);

    assign bus.Csr_Req    = in_csr;
    assign bus.Csr_Op     = in_csr ? held_op   : '0;
    assign bus.Csr_Addr   = in_csr ? held_addr : '0;
    assign bus.Csr_WrData = in_csr ? held_src  : '0;

    assign bus.Wakeup_Valid   = in_wb & ~bus.Stall;
    assign bus.Wakeup_RegWE   = in_wb & held_we & ~exc;
    assign bus.Wakeup_PrdType = 1'b0;
    assign bus.Wakeup_Prd     = in_wb ? held_prd : '0;
    assign bus.Cmpl_Valid     = in_wb & ~bus.Stall;
    assign bus.Cmpl_ROBIdx    = in_wb ? held_rob : '0;
    assign bus.Cmpl_Data      = in_wb ? result   : '0;
    assign bus.Cmpl_Exception = in_wb & exc;
endmodule

// File: tb/tb_sys_issue_exec.sv
// tb/tb_sys_issue_exec.sv - directed and randomized self-checking bench for sys_issue_exec
module tb_sys_issue_exec;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sys_issue_exec_if bus ();

    sys_issue_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Stall           = 1'b0;
        bus.Flush           = 1'b0;
        bus.Kill_Enable     = 1'b0;
        bus.Update_KillMask = 1'b0;
        bus.FUBR_SpecTag    = '0;
        bus.Req_Valid       = 1'b0;
        bus.Req_ROBIdx      = '0;
        bus.Req_KillMask    = '0;
        bus.Req_Prd         = '0;
        bus.Req_PrdWe       = 1'b0;
        bus.Req_Op          = '0;
        bus.Req_CsrAddr     = '0;
        bus.Req_Src1        = '0;
        bus.ROB_HeadIdx     = '0;
        bus.Csr_Ack         = 1'b0;
        bus.Csr_RdData      = '0;
        bus.Csr_Fault       = 1'b0;
    endtask

    // One system uop from issue to retirement. kmode 0: no matching kill (a
    // non-matching kill may occur), 1: matching kill on the last wait cycle,
    // 2: branch bit cleared at issue then a kill on that bit (uop survives).
    task automatic run_txn(input logic [5:0] rob, input logic [3:0] km, input logic [6:0] prd,
                           input logic we, input logic [2:0] op, input logic [11:0] addr,
                           input logic [63:0] src, input int hw, input int kmode, input int ad,
                           input logic to, input logic [63:0] rd, input logic flt, input int wbst);
        logic [3:0]  tag;
        logic [3:0]  ntag;
        int          exp_n;
        int          n;
        logic        exp_exc;
        logic [63:0] exp_data;
        tag  = 4'b0000;
        ntag = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (km[i])  tag  = 4'b0001 << i;
            if (!km[i]) ntag = 4'b0001 << i;
        end
        exp_n    = to ? 16 : ad + 1;
        exp_exc  = to ? 1'b1 : flt;
        exp_data = to ? 64'd0 : rd;

        bus.Req_Valid       = 1'b1;
        bus.Req_ROBIdx      = rob;
        bus.Req_KillMask    = km;
        bus.Req_Prd         = prd;
        bus.Req_PrdWe       = we;
        bus.Req_Op          = op;
        bus.Req_CsrAddr     = addr;
        bus.Req_Src1        = src;
        bus.ROB_HeadIdx     = rob + 6'd1;
        bus.Update_KillMask = (kmode == 2);
        bus.FUBR_SpecTag    = tag;
        @(negedge clk);
        chk("issue_valid", bus.RSSYS_Issued_Valid, 1);
        chk("issue_not_busy", bus.Sys_Busy, 0);
        next_cyc();
        bus.Req_Valid       = 1'b0;
        bus.Update_KillMask = 1'b0;
        bus.Req_Prd         = 7'($urandom);
        bus.Req_Op          = 3'($urandom);
        bus.Req_CsrAddr     = 12'($urandom);
        bus.Req_Src1        = {$urandom, $urandom};
        bus.Req_ROBIdx      = 6'($urandom);

        for (int i = 0; i < hw; i++) begin
            bus.Kill_Enable  = 1'b0;
            bus.FUBR_SpecTag = '0;
            bus.Stall        = 1'($urandom);
            if (kmode == 1 && i == hw - 1) begin
                bus.Kill_Enable  = 1'b1;
                bus.FUBR_SpecTag = tag;
            end else if (kmode == 2 && i == 0) begin
                bus.Kill_Enable  = 1'b1;
                bus.FUBR_SpecTag = tag;
            end else if (kmode == 0 && km != 4'hF && i == 0) begin
                bus.Kill_Enable  = 1'b1;
                bus.FUBR_SpecTag = ntag;
            end
            @(negedge clk);
            chk("wait_no_csr", bus.Csr_Req, 0);
            chk("wait_busy", bus.Sys_Busy, 1);
            chk("wait_no_cmpl", bus.Cmpl_Valid, 0);
            next_cyc();
            bus.Kill_Enable  = 1'b0;
            bus.FUBR_SpecTag = '0;
            bus.Stall        = 1'b0;
            if (kmode == 1 && i == hw - 1) begin
                @(negedge clk);
                chk("kill_idle", bus.Sys_Busy, 0);
                chk("kill_no_csr", bus.Csr_Req, 0);
                chk("kill_no_cmpl", bus.Cmpl_Valid, 0);
                chk("kill_no_wakeup", bus.Wakeup_Valid, 0);
                next_cyc();
                return;
            end
        end

        bus.ROB_HeadIdx = rob;
        @(negedge clk);
        chk("head_cycle_no_csr", bus.Csr_Req, 0);
        next_cyc();
        bus.ROB_HeadIdx = rob + 6'd2;

        n = 0;
        for (int t = 0; t < 40; t++) begin
            bus.Csr_Ack    = (!to && t == ad);
            bus.Csr_RdData = (!to && t == ad) ? rd : {$urandom, $urandom};
            bus.Csr_Fault  = (!to && t == ad) ? flt : 1'($urandom);
            bus.Stall      = (t < exp_n) ? 1'($urandom) : (wbst > 0);
            @(negedge clk);
            if (!bus.Csr_Req) break;
            n++;
            if (t == 0 || t == exp_n - 1) begin
                chk("csr_op", bus.Csr_Op, op);
                chk("csr_addr", bus.Csr_Addr, addr);
                chk("csr_wrdata", bus.Csr_WrData, src);
            end
            next_cyc();
        end
        chk("csr_req_cycles", n, exp_n);
        bus.Csr_Ack = 1'b0;

        for (int s = 0; s < wbst; s++) begin
            chk("wb_stall_no_cmpl", bus.Cmpl_Valid, 0);
            chk("wb_stall_busy", bus.Sys_Busy, 1);
            next_cyc();
            bus.Stall = (s + 1 < wbst);
            @(negedge clk);
        end
        chk("wb_cmpl_valid", bus.Cmpl_Valid, 1);
        chk("wb_wakeup_valid", bus.Wakeup_Valid, 1);
        chk("wb_regwe", bus.Wakeup_RegWE, we & ~exp_exc);
        chk("wb_prd", bus.Wakeup_Prd, prd);
        chk("wb_prdtype", bus.Wakeup_PrdType, 0);
        chk("wb_robidx", bus.Cmpl_ROBIdx, rob);
        chk("wb_data", bus.Cmpl_Data, exp_data);
        chk("wb_exception", bus.Cmpl_Exception, exp_exc);
        next_cyc();
        bus.Stall = 1'b0;
        @(negedge clk);
        chk("post_wb_idle", bus.Sys_Busy, 0);
        chk("post_wb_no_cmpl", bus.Cmpl_Valid, 0);
        next_cyc();
    endtask

    initial begin
        int          kmode;
        int          hw;
        int          ad;
        int          wbst;
        logic [3:0]  km;
        logic        to;
        checks = 0;
        errors = 0;
        clear_inputs();
        rst = 1'b1;
        next_cyc();
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.Sys_Busy, 0);
        chk("rst_csr_req", bus.Csr_Req, 0);
        chk("rst_cmpl", bus.Cmpl_Valid, 0);
        chk("rst_wakeup", bus.Wakeup_Valid, 0);
        chk("rst_issued", bus.RSSYS_Issued_Valid, 0);
        next_cyc();

        run_txn(6'd5, 4'b0000, 7'h21, 1'b1, 3'd2, 12'h300, 64'h1234, 0, 0, 1, 1'b0,
                64'hABCD, 1'b0, 0);
        run_txn(6'd7, 4'b0010, 7'h11, 1'b1, 3'd1, 12'h305, 64'h55, 4, 1, 0, 1'b0,
                64'h0, 1'b0, 0);
        run_txn(6'd8, 4'b0100, 7'h12, 1'b1, 3'd3, 12'h341, 64'h77, 2, 2, 2, 1'b0,
                64'hBEEF, 1'b0, 0);

        bus.Req_Valid    = 1'b1;
        bus.Req_KillMask = 4'b0001;
        bus.Stall        = 1'b1;
        @(negedge clk);
        chk("blocked_stall", bus.RSSYS_Issued_Valid, 0);
        next_cyc();
        bus.Stall        = 1'b0;
        bus.Kill_Enable  = 1'b1;
        bus.FUBR_SpecTag = 4'b0001;
        @(negedge clk);
        chk("blocked_kill", bus.RSSYS_Issued_Valid, 0);
        chk("blocked_kill_idle", bus.Sys_Busy, 0);
        next_cyc();
        bus.Kill_Enable  = 1'b0;
        bus.FUBR_SpecTag = '0;
        bus.Flush        = 1'b1;
        @(negedge clk);
        chk("blocked_flush", bus.RSSYS_Issued_Valid, 0);
        next_cyc();
        clear_inputs();
        @(negedge clk);
        chk("blocked_still_idle", bus.Sys_Busy, 0);
        next_cyc();

        run_txn(6'd12, 4'b0000, 7'h33, 1'b1, 3'd4, 12'h7C0, 64'h99, 1, 0, 0, 1'b1,
                64'h0, 1'b0, 0);
        run_txn(6'd13, 4'b0000, 7'h34, 1'b1, 3'd5, 12'h7C1, 64'h9A, 0, 0, 15, 1'b0,
                64'hFACE, 1'b0, 0);

        bus.Req_Valid   = 1'b1;
        bus.Req_ROBIdx  = 6'd9;
        bus.Req_Prd     = 7'h44;
        bus.Req_PrdWe   = 1'b1;
        bus.ROB_HeadIdx = 6'd9;
        @(negedge clk);
        chk("flush_issue", bus.RSSYS_Issued_Valid, 1);
        next_cyc();
        bus.Req_Valid = 1'b0;
        next_cyc();
        for (int c = 0; c < 3; c++) begin
            bus.Flush = (c == 2);
            @(negedge clk);
            chk("flush_csr_req_high", bus.Csr_Req, 1);
            next_cyc();
        end
        bus.Flush      = 1'b0;
        bus.Csr_Ack    = 1'b1;
        bus.Csr_RdData = 64'h5;
        @(negedge clk);
        chk("flush_csr_req_drop", bus.Csr_Req, 0);
        chk("flush_idle", bus.Sys_Busy, 0);
        chk("flush_no_cmpl", bus.Cmpl_Valid, 0);
        next_cyc();
        bus.Csr_Ack = 1'b0;
        @(negedge clk);
        chk("flush_late_ack_no_cmpl", bus.Cmpl_Valid, 0);
        chk("flush_late_ack_idle", bus.Sys_Busy, 0);
        next_cyc();

        run_txn(6'd20, 4'b1000, 7'h55, 1'b1, 3'd6, 12'h001, 64'h42, 1, 0, 2, 1'b0,
                64'h1111, 1'b1, 2);

        for (int k = 0; k < 40; k++) begin
            km    = 4'($urandom);
            kmode = int'($urandom % 3);
            if (km == 4'b0000) kmode = 0;
            hw    = int'($urandom_range(0, 3));
            if (kmode != 0 && hw == 0) hw = 1;
            to    = ($urandom % 6 == 0);
            ad    = (($urandom % 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            wbst  = int'($urandom_range(0, 2));
            run_txn(6'($urandom), km, 7'($urandom), 1'($urandom), 3'($urandom), 12'($urandom),
                    {$urandom, $urandom}, hw, kmode, ad, to, {$urandom, $urandom},
                    1'($urandom), wbst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
